// File: rtl/apb_uart_pkg.sv
// ============================================================================
// Module : apb_uart_pkg
// Brief  : Shared FSM encoding, STATUS bit map and parameter defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_uart_pkg;

  localparam int c_DEF_DATA_W      = 8;
  localparam int c_DEF_ADDR_W      = 2;
  localparam int c_DEF_SLAVE_COUNT = 2;
  localparam int c_DEF_CS_W        = 2;
  localparam int c_DEF_WAIT_STATES = 0;

  // Wide enough for the full 0..15 wait-state range
  localparam int c_CNT_W = 4;

  localparam int c_ST_TX_RDY = 0;
  localparam int c_ST_RX_RDY = 1;
  localparam int c_ST_RXOUT  = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_sync2.sv
// ============================================================================
// Module : apb_sync2
// Brief  : Two-flop synchroniser for a single asynchronous level input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic presetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/apb_multislave_regs.sv
// ============================================================================
// Module : apb_multislave_regs
// Brief  : APB register banks selected by cs, with wait states and UART status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_multislave_regs
  import apb_uart_pkg::*;
#(
  parameter int DATA_W      = c_DEF_DATA_W,
  parameter int ADDR_W      = c_DEF_ADDR_W,
  parameter int SLAVE_COUNT = c_DEF_SLAVE_COUNT,
  parameter int CS_W        = c_DEF_CS_W,
  parameter int WAIT_STATES = c_DEF_WAIT_STATES
) (
  input  logic                                       pclk,
  input  logic                                       presetn,
  input  logic                                       psel,
  input  logic                                       penable,
  input  logic                                       pwrite,
  input  logic [ADDR_W-1:0]                          P_ADDR,
  input  logic [DATA_W-1:0]                          PW_DATA,
  input  logic [CS_W-1:0]                            cs,
  output logic [DATA_W-1:0]                          Pr_data,
  output logic                                       P_READY,
  output logic                                       P_SLVERR,
  input  logic                                       rx,
  input  logic                                       tf_TXRDY,
  input  logic                                       rbuff_RXRDY,
  output logic [SLAVE_COUNT*(2**ADDR_W)*DATA_W-1:0]  o_regs,
  output logic [DATA_W-1:0]                          o_baud_val,
  output logic [DATA_W-1:0]                          data_in,
  output logic                                       RXOUT,
  output logic                                       TX_RDY,
  output logic                                       RX_RDY
);

  localparam int NREG = 2**ADDR_W;

  apb_state_e           r_state;
  apb_state_e           w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  logic                 w_cs_ok;
  logic                 w_is_status;
  logic                 w_done;
  logic                 w_err;
  logic                 w_wr_en;
  logic [DATA_W-1:0]    w_status;
  logic [DATA_W-1:0]    w_rd_sel;
  logic [SLAVE_COUNT*NREG*DATA_W-1:0] w_regs;

  apb_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk(pclk), .presetn(presetn), .i_d(rx), .o_q(RXOUT)
  );
  apb_sync2 #(.RESET_VAL(1'b0)) u_sync_tx (
    .clk(pclk), .presetn(presetn), .i_d(tf_TXRDY), .o_q(TX_RDY)
  );
  apb_sync2 #(.RESET_VAL(1'b0)) u_sync_rxrdy (
    .clk(pclk), .presetn(presetn), .i_d(rbuff_RXRDY), .o_q(RX_RDY)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = c_CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          w_state_nxt = IDLE;
        end else if (penable) begin
          if (r_cnt != '0) w_cnt_nxt   = r_cnt - 1'b1;
          else             w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cs_ok     = int'(cs) < SLAVE_COUNT;
  assign w_is_status = (cs == '0) && (P_ADDR == ADDR_W'(NREG-1));
  assign w_done      = (r_state == ACCESS) && psel && penable && (r_cnt == '0);
  assign w_err       = !w_cs_ok || (pwrite && w_is_status);
  assign w_wr_en     = w_done && pwrite && !w_err;

  assign P_READY  = (r_state != ACCESS) || (r_cnt == '0);
  assign P_SLVERR = w_done && w_err;

  always_comb begin
    w_status              = '0;
    w_status[c_ST_TX_RDY] = TX_RDY;
    w_status[c_ST_RX_RDY] = RX_RDY;
    w_status[c_ST_RXOUT]  = RXOUT;
  end

  // Bank0's top slot holds no storage; it reads back live STATUS instead
  for (genvar s = 0; s < SLAVE_COUNT; s++) begin : g_bank
    for (genvar r = 0; r < NREG; r++) begin : g_reg
      if (s == 0 && r == NREG-1) begin : g_status
        assign w_regs[(s*NREG+r)*DATA_W +: DATA_W] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] r_val;
        always_ff @(posedge pclk or negedge presetn) begin
          if (!presetn) begin
            r_val <= '0;
          end else if (w_wr_en && (cs == CS_W'(s)) && (P_ADDR == ADDR_W'(r))) begin
            r_val <= PW_DATA;
          end
        end
        assign w_regs[(s*NREG+r)*DATA_W +: DATA_W] = r_val;
      end
    end
  end

  always_comb begin
    w_rd_sel = '0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      for (int r = 0; r < NREG; r++) begin
        if ((cs == CS_W'(s)) && (P_ADDR == ADDR_W'(r))) begin
          w_rd_sel = w_regs[(s*NREG+r)*DATA_W +: DATA_W];
        end
      end
    end
    if (w_is_status) w_rd_sel = w_status;
  end

  assign Pr_data    = (w_done && !pwrite && !w_err) ? w_rd_sel : '0;
  assign o_regs     = w_regs;
  assign o_baud_val = w_regs[0 +: DATA_W];
  assign data_in    = w_regs[(1*NREG+2)*DATA_W +: DATA_W];

endmodule

`default_nettype wire

// File: tb/tb_apb_multislave_regs.sv
// ============================================================================
// Module : tb_apb_multislave_regs
// Brief  : Scoreboard bench for apb_multislave_regs at WAIT_STATES 0 and 3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_multislave_regs;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [1:0] paddr = '0, cs = '0;
  logic [7:0] pwdata = '0;
  logic       rx = 1'b1, tf_TXRDY = 1'b0, rbuff_RXRDY = 1'b0;

  logic [7:0]  prdata0, prdata3, baud0, baud3, din0, din3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [63:0] regs0, regs3;
  logic        rxout0, rxout3, txrdy0, txrdy3, rxrdy0, rxrdy3;

  apb_multislave_regs #(.DATA_W(8), .ADDR_W(2), .SLAVE_COUNT(2), .CS_W(2), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .P_ADDR(paddr), .PW_DATA(pwdata), .cs(cs), .Pr_data(prdata0), .P_READY(pready0),
    .P_SLVERR(pslverr0), .rx(rx), .tf_TXRDY(tf_TXRDY), .rbuff_RXRDY(rbuff_RXRDY),
    .o_regs(regs0), .o_baud_val(baud0), .data_in(din0), .RXOUT(rxout0),
    .TX_RDY(txrdy0), .RX_RDY(rxrdy0)
  );

  apb_multislave_regs #(.DATA_W(8), .ADDR_W(2), .SLAVE_COUNT(2), .CS_W(2), .WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .P_ADDR(paddr), .PW_DATA(pwdata), .cs(cs), .Pr_data(prdata3), .P_READY(pready3),
    .P_SLVERR(pslverr3), .rx(rx), .tf_TXRDY(tf_TXRDY), .rbuff_RXRDY(rbuff_RXRDY),
    .o_regs(regs3), .o_baud_val(baud3), .data_in(din3), .RXOUT(rxout3),
    .TX_RDY(txrdy3), .RX_RDY(rxrdy3)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         waits;
  } xact_t;

  xact_t      sb[$];
  xact_t      ob[$];
  logic [7:0] mdl [2][8];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [63:0] exp_regs(input int d);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mdl[d][i];
    return v;
  endfunction

  function automatic logic [63:0] act_regs(input int d);
    return (d == 0) ? regs0 : regs3;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) mdl[d][i] = 8'h00;
  endtask

  task automatic bus_idle();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  // Drives one transfer from a posedge+1 starting point; leaves psel asserted
  task automatic xfer(input int d, input logic wr, input logic [1:0] c,
                      input logic [1:0] a, input logic [7:0] v);
    xact_t o;
    psel0 = (d == 0); psel3 = (d != 0);
    penable = 1'b0; pwrite = wr; cs = c; paddr = a; pwdata = v;
    @(posedge pclk); #1 penable = 1'b1;
    o.waits = 0;
    forever begin
      @(negedge pclk);
      if (((d == 0) ? pready0 : pready3) === 1'b1) break;
      o.waits++;
      if (o.waits > 32) break;
      @(posedge pclk); #1;
    end
    o.rd  = (d == 0) ? prdata0 : prdata3;
    o.err = (d == 0) ? pslverr0 : pslverr3;
    ob.push_back(o);
    @(posedge pclk); #1;
  endtask

  task automatic issue(input int d, input logic wr, input logic [1:0] c,
                       input logic [1:0] a, input logic [7:0] v);
    xact_t e;
    logic  bad;
    bad     = (c > 2'd1) || (wr && c == 2'd0 && a == 2'd3);
    e.err   = bad;
    e.waits = (d == 0) ? 0 : 3;
    e.rd    = 8'h00;
    if (!bad && wr) mdl[d][{c[0], a}] = v;
    if (!bad && !wr)
      e.rd = (c == 2'd0 && a == 2'd3) ? {5'b0, rx, rbuff_RXRDY, tf_TXRDY} : mdl[d][{c[0], a}];
    sb.push_back(e);
    xfer(d, wr, c, a, v);
  endtask

  task automatic test_reset();
    clear_model();
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    n_cmp++; if (pready0 !== 1'b1 || pready3 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b/%b want 1/1", pready0, pready3); end
    n_cmp++; if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) begin n_bad++; $display("FAIL reset_slverr: got %b/%b want 0/0", pslverr0, pslverr3); end
    n_cmp++; if (prdata0 !== 8'h00 || prdata3 !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 00/00", prdata0, prdata3); end
    n_cmp++; if (regs0 !== 64'h0 || regs3 !== 64'h0) begin n_bad++; $display("FAIL reset_regs: got %h/%h want 0", regs0, regs3); end
    n_cmp++; if ({rxout0, txrdy0, rxrdy0} !== 3'b100) begin n_bad++; $display("FAIL reset_sync: got %b want 100", {rxout0, txrdy0, rxrdy0}); end
    presetn = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if ({rxout3, txrdy3, rxrdy3} !== 3'b100) begin n_bad++; $display("FAIL post_reset_sync: got %b want 100", {rxout3, txrdy3, rxrdy3}); end
  endtask

  task automatic test_write_read();
    xact_t e, o;
    issue(0, 1'b1, 2'd1, 2'd2, 8'hA5); bus_idle();
    @(posedge pclk); #1;
    n_cmp++; if (din0 !== 8'hA5) begin n_bad++; $display("FAIL data_in: got %h want a5", din0); end
    issue(0, 1'b0, 2'd1, 2'd2, 8'h00); bus_idle();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 2'(i >> 1), 2'(i), 8'(8'h30 + i * 17)); bus_idle();
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 2'(i >> 1), 2'(i), 8'h00); bus_idle();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL wr_rd_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL wr_rd_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
    n_cmp++; if (regs0 !== exp_regs(0)) begin n_bad++; $display("FAIL wr_rd_regs: got %h want %h", regs0, exp_regs(0)); end
  endtask

  task automatic test_wait_states();
    xact_t e, o;
    issue(1, 1'b1, 2'd0, 2'd0, 8'h5A); bus_idle();
    issue(1, 1'b0, 2'd0, 2'd0, 8'h00); bus_idle();
    issue(1, 1'b1, 2'd1, 2'd3, 8'hC7); bus_idle();
    issue(1, 1'b0, 2'd1, 2'd3, 8'h00); bus_idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL ws_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL ws_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
    n_cmp++; if (baud3 !== 8'h5A) begin n_bad++; $display("FAIL ws_baud: got %h want 5a", baud3); end
  endtask

  task automatic test_errors();
    xact_t e, o;
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 2'd3, 2'd1, 8'hFF); bus_idle();
      issue(d, 1'b1, 2'd0, 2'd3, 8'h77); bus_idle();
      issue(d, 1'b1, 2'd2, 2'd0, 8'h99); bus_idle();
      issue(d, 1'b0, 2'd2, 2'd2, 8'h00); bus_idle();
      issue(d, 1'b0, 2'd3, 2'd0, 8'h00); bus_idle();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL err_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL err_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
    n_cmp++; if (regs0 !== exp_regs(0)) begin n_bad++; $display("FAIL err_regs0: got %h want %h", regs0, exp_regs(0)); end
    n_cmp++; if (regs3 !== exp_regs(1)) begin n_bad++; $display("FAIL err_regs3: got %h want %h", regs3, exp_regs(1)); end
  endtask

  task automatic test_status();
    xact_t e, o;
    rx = 1'b0; tf_TXRDY = 1'b1;
    @(posedge pclk); #1;
    n_cmp++; if (rxout0 !== 1'b1 || txrdy0 !== 1'b0) begin n_bad++; $display("FAIL sync_one_edge: got %b%b want 10", rxout0, txrdy0); end
    @(posedge pclk); #1;
    n_cmp++; if (rxout0 !== 1'b0 || txrdy0 !== 1'b1 || rxout3 !== 1'b0 || txrdy3 !== 1'b1) begin
      n_bad++; $display("FAIL sync_two_edges: got %b%b/%b%b want 01/01", rxout0, txrdy0, rxout3, txrdy3);
    end
    issue(0, 1'b0, 2'd0, 2'd3, 8'h00); bus_idle();
    issue(1, 1'b0, 2'd0, 2'd3, 8'h00); bus_idle();
    rbuff_RXRDY = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    issue(0, 1'b0, 2'd0, 2'd3, 8'h00); bus_idle();
    rx = 1'b1; tf_TXRDY = 1'b0; rbuff_RXRDY = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    issue(1, 1'b0, 2'd0, 2'd3, 8'h00); bus_idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL status_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL status_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
  endtask

  task automatic test_back_to_back();
    xact_t e, o;
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b1, 2'd1, 2'd1, 8'(8'h61 + d));
      issue(d, 1'b0, 2'd1, 2'd1, 8'h00);
      issue(d, 1'b1, 2'd0, 2'd2, 8'(8'h9E - d));
      issue(d, 1'b0, 2'd0, 2'd2, 8'h00);
      issue(d, 1'b0, 2'd1, 2'd2, 8'h00);
      bus_idle();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL b2b_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL b2b_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
  endtask

  task automatic test_abort();
    xact_t e, o;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; cs = 2'd1; paddr = 2'd0; pwdata = 8'hEE;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 bus_idle();
    @(posedge pclk); #1;
    n_cmp++; if (regs3 !== exp_regs(1)) begin n_bad++; $display("FAIL abort_regs: got %h want %h", regs3, exp_regs(1)); end
    issue(1, 1'b0, 2'd1, 2'd0, 8'h00); bus_idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL abort_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL abort_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
  endtask

  task automatic test_reset_mid();
    xact_t e, o;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; cs = 2'd0; paddr = 2'd1; pwdata = 8'h3C;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0; bus_idle();
    clear_model();
    @(posedge pclk); #1;
    n_cmp++; if (regs3 !== 64'h0 || pready3 !== 1'b1) begin n_bad++; $display("FAIL mid_reset: got regs=%h ready=%b want 0/1", regs3, pready3); end
    presetn = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    n_cmp++; if (regs3[15:8] !== 8'h00) begin n_bad++; $display("FAIL mid_reset_b0r1: got %h want 00", regs3[15:8]); end
    issue(1, 1'b1, 2'd0, 2'd1, 8'h3C); bus_idle();
    issue(1, 1'b0, 2'd0, 2'd1, 8'h00); bus_idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (ob.size() == 0) begin n_bad++; $display("FAIL post_reset_resp: got none want 1"); continue; end
      o = ob.pop_front();
      if (o.rd !== e.rd || o.err !== e.err || o.waits != e.waits) begin
        n_bad++; $display("FAIL post_reset_xact: got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d", o.rd, o.err, o.waits, e.rd, e.err, e.waits);
      end
    end
    n_cmp++; if (act_regs(1) !== exp_regs(1)) begin n_bad++; $display("FAIL post_reset_regs: got %h want %h", act_regs(1), exp_regs(1)); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_status();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/apb_multislave_regs.md
APB_MULTISLAVE_REGS -- requirements
Module: apb_multislave_regs

Interface
REQ-001 Parameter DATA_W, 8, register and APB data width.
REQ-002 Parameter ADDR_W, 2, register index width; NREG = 2**ADDR_W registers per slave.
REQ-003 Parameter SLAVE_COUNT, 2, number of register banks selected by cs.
REQ-004 Parameter CS_W, 2, cs width.
REQ-005 Parameter WAIT_STATES, 0, access-phase wait cycles (0..15) inserted before P_READY.
REQ-006 Clock and reset SHALL be a single clock pclk and an asynchronous, active-low reset presetn.
REQ-007 pclk  in  1  APB clock; all state updates on rising edge.
REQ-008 presetn  in  1  asynchronous active-low reset.
REQ-009 psel, penable, pwrite  in  1 each  APB control.
REQ-010 P_ADDR  in  ADDR_W  register index within the selected bank.
REQ-011 PW_DATA  in  DATA_W  write data.
REQ-012 cs  in  CS_W  bank select.
REQ-013 Pr_data  out  DATA_W  read data.
REQ-014 P_READY  out  1  transfer-complete.
REQ-015 P_SLVERR  out  1  transfer error, valid only with P_READY in access.
REQ-016 rx, tf_TXRDY, rbuff_RXRDY  in  1 each  asynchronous UART status inputs.
REQ-017 o_regs  out  SLAVE_COUNT*NREG*DATA_W  flattened bank contents; bank s, index r at bits [(s*NREG+r)*DATA_W +: DATA_W].
REQ-018 o_baud_val, data_in  out  DATA_W  bank0[0] and bank1[2] (requires SLAVE_COUNT>=2, ADDR_W>=2).
REQ-019 RXOUT, TX_RDY, RX_RDY  out  1  synchronised rx, tf_TXRDY, rbuff_RXRDY.

Function
REQ-020 FSM SHALL have states IDLE and ACCESS; IDLE->ACCESS when psel && !penable, loading wait counter with WAIT_STATES.
REQ-021 In ACCESS with counter != 0 and psel && penable, counter SHALL decrement and P_READY SHALL be 0.
REQ-022 In ACCESS with counter == 0 and psel && penable, P_READY SHALL be 1 (combinational), the transfer completes, and the FSM SHALL return to IDLE.
REQ-023 In ACCESS, if psel drops, the FSM SHALL return to IDLE with no register write (abort).
REQ-024 Outside ACCESS, P_READY SHALL be 1; total latency from setup = WAIT_STATES+1 access cycles.
REQ-025 Write SHALL commit bank[cs][P_ADDR] <= PW_DATA on the completing edge only, when cs < SLAVE_COUNT and the target is not STATUS.
REQ-026 Bank0 index NREG-1 SHALL be read-only STATUS = {0, RXOUT, RX_RDY, TX_RDY} (bits 2:0).
REQ-027 Pr_data SHALL show bank[cs][P_ADDR] (STATUS when addressed) during a completing read, else 0.
REQ-028 P_SLVERR SHALL be 1 in the completing cycle if cs >= SLAVE_COUNT or on a write to STATUS; no state changes; read returns 0.
REQ-029 Back-to-back transfers (setup immediately after completion) SHALL be accepted with no idle cycle.
REQ-030 Each status input SHALL pass a two-flop synchroniser; outputs lag inputs by 2 rising edges.

Reset
REQ-031 presetn low SHALL immediately force state IDLE, counter 0, all bank registers 0, P_READY 1, P_SLVERR 0, Pr_data 0.
REQ-032 Synchroniser flops SHALL reset to rx=1, tf_TXRDY=0, rbuff_RXRDY=0 (RXOUT=1, TX_RDY=0, RX_RDY=0).
REQ-033 Reset asserted mid-transfer SHALL abandon it with no write; first post-reset transfer behaves normally.

Structure
REQ-034 Package apb_uart_pkg SHALL hold the FSM state encoding, STATUS bit positions and parameter defaults.
REQ-035 Synchroniser SHALL be sub-module apb_sync2 (parameter RESET_VAL), instantiated three times.

Verification
REQ-036 WAIT_STATES=0: write cs=1, P_ADDR=2, 0xA5 -> P_READY in first access cycle; data_in=0xA5; read returns 0xA5.
REQ-037 WAIT_STATES=3: read cs=0, P_ADDR=0 -> P_READY low 3 access cycles, high on 4th; Pr_data=o_baud_val.
REQ-038 Write cs=3 (SLAVE_COUNT=2) or write bank0 index 3 -> P_SLVERR=1 with P_READY; o_regs unchanged.
REQ-039 Drive rx=0, tf_TXRDY=1 -> RXOUT=0, TX_RDY=1 after 2 edges; STATUS read returns 0x01.
REQ-040 Assert presetn low during WAIT_STATES=3 write to bank0[1]=0x3C -> bank0[1] stays 0; next write succeeds.
